write_reg_select_pipe: RTL and testbench

Parametrised successor to the writeback register-select mux. It picks the destination register index (regB, destReg or a fixed link register) and carries the write through a STAGES-deep writeback delay pipeline to the register-file write port. It also exposes a pending-write scoreboard and two forwarding lookup ports for hazard detection and bypass in the pipelined LC2K core.

---
 rtl/write_reg_select_pipe.sv | 138 +++++++++++++
 tb/tb_write_reg_select_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_reg_select_pipe.sv
// Writeback register select with a STAGES-deep delay pipeline.
// Exposes a pending-write scoreboard and two forwarding lookup ports.
module write_reg_select_pipe #(
  parameter int REG_ADDR_W        = 3,
  parameter int DATA_W            = 32,
  parameter int STAGES            = 2,
  parameter int LINK_REG          = 7,
  parameter int ZERO_REG_WRITABLE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [1:0]                   sel_mode,
  input  logic [REG_ADDR_W-1:0]        regB,
  input  logic [REG_ADDR_W-1:0]        destReg,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         wr_en,
  output logic [REG_ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [(1<<REG_ADDR_W)-1:0]   pending,
  input  logic [REG_ADDR_W-1:0]        qa_addr,
  input  logic [REG_ADDR_W-1:0]        qb_addr,
  output logic                         qa_hit,
  output logic                         qb_hit,
  output logic [DATA_W-1:0]            qa_data,
  output logic [DATA_W-1:0]            qb_data
);

  localparam int LAST = STAGES - 1;
  localparam bit ZERO_DROP = (ZERO_REG_WRITABLE == 0);
  localparam logic [REG_ADDR_W-1:0] LINK_ADDR =
    REG_ADDR_W'(LINK_REG);

  logic [STAGES-1:0]     st_valid;
  logic [REG_ADDR_W-1:0] st_addr [STAGES];
  logic [DATA_W-1:0]     st_data [STAGES];

  logic                  new_valid;
  logic [REG_ADDR_W-1:0] new_addr;
  logic                  new_wr;

  always_comb begin
    new_addr = '0;
    new_wr   = 1'b0;
    unique case (sel_mode)
      2'd0: begin
        new_addr = regB;
        new_wr   = 1'b1;
      end
      2'd1: begin
        new_addr = destReg;
        new_wr   = 1'b1;
      end
      2'd2: begin
        new_addr = LINK_ADDR;
        new_wr   = 1'b1;
      end
      2'd3: begin
        new_addr = '0;
        new_wr   = 1'b0;
      end
    endcase
  end

  // Writes to r0 are dropped at capture so they never reach
  // pending, forwarding or the register file.
  assign new_valid = in_valid && new_wr &&
    !(ZERO_DROP && (new_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        st_addr[i] <= '0;
        st_data[i] <= '0;
      end
    end else if (flush) begin
      // Last stage commits this cycle unless stalled, so it
      // only survives the flush when it is being held.
      for (int i = 0; i < LAST; i++) begin
        st_valid[i] <= 1'b0;
      end
      if (!stall) begin
        st_valid[LAST] <= 1'b0;
      end
    end else if (!stall) begin
      st_valid[0] <= new_valid;
      st_addr[0]  <= new_addr;
      st_data[0]  <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_addr[i]  <= st_addr[i-1];
        st_data[i]  <= st_data[i-1];
      end
    end
  end

  assign wr_en   = st_valid[LAST] && !stall;
  assign wr_addr = st_addr[LAST];
  assign wr_data = st_data[LAST];

  always_comb begin
    pending = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (st_valid[i]) begin
        pending[st_addr[i]] = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  function automatic logic [DATA_W:0] fwd(
    input logic [REG_ADDR_W-1:0] q
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int i = LAST; i >= 0; i--) begin
      if (st_valid[i] && (st_addr[i] == q)) begin
        r = {1'b1, st_data[i]};
      end
    end
    if (ZERO_DROP && (q == '0)) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    {qa_hit, qa_data} = fwd(qa_addr);
  end

  always_comb begin
    {qb_hit, qb_data} = fwd(qb_addr);
  end

endmodule

// File: tb/tb_write_reg_select_pipe.sv
// Scoreboard bench for write_reg_select_pipe across three
// configurations; commits are checked for address, data and cycle.
module tb_write_reg_select_pipe;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  logic        in_valid [3];
  logic [1:0]  sel_mode [3];
  logic [2:0]  regB     [3];
  logic [2:0]  destReg  [3];
  logic [31:0] in_data  [3];
  logic        stall    [3];
  logic        flush    [3];
  logic [2:0]  qa_addr  [3];
  logic [2:0]  qb_addr  [3];
  logic        wr_en    [3];
  logic [2:0]  wr_addr  [3];
  logic [31:0] wr_data  [3];
  logic [7:0]  pending  [3];
  logic        qa_hit   [3];
  logic        qb_hit   [3];
  logic [31:0] qa_data  [3];
  logic [31:0] qb_data  [3];

  typedef struct {
    int          dut;
    logic [2:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   c0;

  write_reg_select_pipe #(
    .REG_ADDR_W(3), .DATA_W(32), .STAGES(2),
    .LINK_REG(7), .ZERO_REG_WRITABLE(0)
  ) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .sel_mode(sel_mode[0]),
    .regB(regB[0]), .destReg(destReg[0]),
    .in_data(in_data[0]), .stall(stall[0]), .flush(flush[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .pending(pending[0]),
    .qa_addr(qa_addr[0]), .qb_addr(qb_addr[0]),
    .qa_hit(qa_hit[0]), .qb_hit(qb_hit[0]),
    .qa_data(qa_data[0]), .qb_data(qb_data[0])
  );

  write_reg_select_pipe #(
    .REG_ADDR_W(3), .DATA_W(32), .STAGES(3),
    .LINK_REG(7), .ZERO_REG_WRITABLE(0)
  ) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .sel_mode(sel_mode[1]),
    .regB(regB[1]), .destReg(destReg[1]),
    .in_data(in_data[1]), .stall(stall[1]), .flush(flush[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .pending(pending[1]),
    .qa_addr(qa_addr[1]), .qb_addr(qb_addr[1]),
    .qa_hit(qa_hit[1]), .qb_hit(qb_hit[1]),
    .qa_data(qa_data[1]), .qb_data(qb_data[1])
  );

  write_reg_select_pipe #(
    .REG_ADDR_W(3), .DATA_W(32), .STAGES(2),
    .LINK_REG(7), .ZERO_REG_WRITABLE(1)
  ) u_z1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .sel_mode(sel_mode[2]),
    .regB(regB[2]), .destReg(destReg[2]),
    .in_data(in_data[2]), .stall(stall[2]), .flush(flush[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .pending(pending[2]),
    .qa_addr(qa_addr[2]), .qb_addr(qb_addr[2]),
    .qa_hit(qa_hit[2]), .qb_hit(qb_hit[2]),
    .qa_data(qa_data[2]), .qb_data(qb_data[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input int k, input logic [2:0] a,
                      input logic [31:0] d, input int c);
    exp_t e;
    e.dut = k; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [1:0] m,
                       input logic [2:0] rb, input logic [2:0] dr,
                       input logic [31:0] d);
    in_valid[k] = 1'b1;
    sel_mode[k] = m;
    regB[k]     = rb;
    destReg[k]  = dr;
    in_data[k]  = d;
  endtask

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
  endtask

  // Commit monitor: every strobe must match the oldest expected
  // entry for that instance, including the cycle it lands in.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_en[k]) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].dut == k) idx = i;
        if (idx < 0) begin
          chk($sformatf("d%0d_unexpected_wr", k), 32'd1, 32'd0);
        end else begin
          chk($sformatf("d%0d_wr_addr", k),
              {29'd0, wr_addr[k]}, {29'd0, sb[idx].addr});
          chk($sformatf("d%0d_wr_data", k),
              wr_data[k], sb[idx].data);
          chk($sformatf("d%0d_wr_cycle", k), cyc, sb[idx].cyc);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 0; sel_mode[k] = 0; regB[k] = 0;
      destReg[k] = 0; in_data[k] = 0; stall[k] = 0;
      flush[k] = 0; qa_addr[k] = 0; qb_addr[k] = 0;
    end

    // Reset state
    step; step;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_rst_wr_en", k), {31'd0, wr_en[k]}, 0);
      chk($sformatf("d%0d_rst_wr_addr", k), {29'd0, wr_addr[k]}, 0);
      chk($sformatf("d%0d_rst_wr_data", k), wr_data[k], 0);
      chk($sformatf("d%0d_rst_pend", k), {24'd0, pending[k]}, 0);
      chk($sformatf("d%0d_rst_qa", k), {31'd0, qa_hit[k]}, 0);
      chk($sformatf("d%0d_rst_qb", k), {31'd0, qb_hit[k]}, 0);
      chk($sformatf("d%0d_rst_qad", k), qa_data[k], 0);
      chk($sformatf("d%0d_rst_qbd", k), qb_data[k], 0);
    end
    step; rst_n = 1'b1;

    // Reset mid-pipeline discards the in-flight write
    step; issue(0, 2'd1, 3'd0, 3'd5, 32'h1234); qa_addr[0] = 3'd5;
    step; idle(0);
    @(negedge clk);
    chk("midrst_pend_before", {24'd0, pending[0]}, 32'h20);
    chk("midrst_qa_before", {31'd0, qa_hit[0]}, 1);
    chk("midrst_qad_before", qa_data[0], 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("midrst_pend", {24'd0, pending[0]}, 0);
    chk("midrst_qa", {31'd0, qa_hit[0]}, 0);
    step; step; rst_n = 1'b1;
    step;

    // Select modes
    step; issue(0, 2'd0, 3'd3, 3'd1, 32'h33); push(0, 3, 32'h33, cyc + 2);
    step; issue(0, 2'd1, 3'd2, 3'd4, 32'h44); push(0, 4, 32'h44, cyc + 2);
    @(negedge clk); chk("sel_pend_a", {24'd0, pending[0]}, 32'h08);
    step; issue(0, 2'd2, 3'd1, 3'd1, 32'h77); push(0, 7, 32'h77, cyc + 2);
    @(negedge clk); chk("sel_pend_b", {24'd0, pending[0]}, 32'h18);
    step; issue(0, 2'd3, 3'd3, 3'd4, 32'h99);
    @(negedge clk); chk("sel_pend_c", {24'd0, pending[0]}, 32'h90);
    step; idle(0);
    @(negedge clk); chk("sel_pend_d", {24'd0, pending[0]}, 32'h80);
    step;
    @(negedge clk); chk("sel_pend_e", {24'd0, pending[0]}, 0);

    // Zero register
    step;
    issue(0, 2'd1, 3'd0, 3'd0, 32'hFFFF);
    issue(2, 2'd1, 3'd0, 3'd0, 32'hFFFF);
    push(2, 0, 32'hFFFF, cyc + 2);
    qa_addr[0] = 3'd0; qa_addr[2] = 3'd0;
    step; idle(0); idle(2);
    @(negedge clk);
    chk("zero_d0_pend", {24'd0, pending[0]}, 0);
    chk("zero_d0_qa", {31'd0, qa_hit[0]}, 0);
    chk("zero_d0_qad", qa_data[0], 0);
    chk("zero_d2_pend", {24'd0, pending[2]}, 32'h01);
    chk("zero_d2_qa", {31'd0, qa_hit[2]}, 1);
    chk("zero_d2_qad", qa_data[2], 32'hFFFF);
    step; step;

    // Forwarding priority, STAGES=3
    qa_addr[1] = 3'd2; qb_addr[1] = 3'd6;
    step; issue(1, 2'd0, 3'd2, 3'd0, 32'hA); push(1, 2, 32'hA, cyc + 3);
    step; issue(1, 2'd0, 3'd2, 3'd0, 32'hB); push(1, 2, 32'hB, cyc + 3);
    @(negedge clk); chk("fwd_qad_a", qa_data[1], 32'hA);
    step; idle(1);
    @(negedge clk);
    chk("fwd_qa_b", {31'd0, qa_hit[1]}, 1);
    chk("fwd_qad_b", qa_data[1], 32'hB);
    chk("fwd_qb_b", {31'd0, qb_hit[1]}, 0);
    chk("fwd_qbd_b", qb_data[1], 0);
    chk("fwd_pend_b", {24'd0, pending[1]}, 32'h04);
    step;
    @(negedge clk); chk("fwd_qad_c", qa_data[1], 32'hB);
    step;
    @(negedge clk); chk("fwd_qad_d", qa_data[1], 32'hB);
    step;
    @(negedge clk); chk("fwd_qa_e", {31'd0, qa_hit[1]}, 0);

    // Stall held 3 cycles at the commit stage
    step; issue(0, 2'd1, 3'd0, 3'd6, 32'h66);
    c0 = cyc; push(0, 6, 32'h66, c0 + 5);
    step; idle(0);
    step; stall[0] = 1'b1; issue(0, 2'd1, 3'd0, 3'd1, 32'h11);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step;
      @(negedge clk);
      chk($sformatf("stall_wr_en_%0d", s), {31'd0, wr_en[0]}, 0);
      chk($sformatf("stall_pend_%0d", s), {24'd0, pending[0]}, 32'h40);
      chk($sformatf("stall_wr_addr_%0d", s), {29'd0, wr_addr[0]}, 6);
    end
    step; stall[0] = 1'b0; idle(0);
    step;
    @(negedge clk); chk("stall_pend_after", {24'd0, pending[0]}, 0);

    // Flush with stall, STAGES=3
    step; issue(1, 2'd1, 3'd0, 3'd1, 32'h1);
    c0 = cyc; push(1, 1, 32'h1, c0 + 4);
    step; issue(1, 2'd1, 3'd0, 3'd2, 32'h2);
    step; issue(1, 2'd1, 3'd0, 3'd3, 32'h3);
    step; idle(1); flush[1] = 1'b1; stall[1] = 1'b1;
    @(negedge clk);
    chk("fs_pend_a", {24'd0, pending[1]}, 32'h0E);
    chk("fs_wr_en_a", {31'd0, wr_en[1]}, 0);
    step; flush[1] = 1'b0; stall[1] = 1'b0;
    @(negedge clk); chk("fs_pend_b", {24'd0, pending[1]}, 32'h02);
    step;
    @(negedge clk); chk("fs_pend_c", {24'd0, pending[1]}, 0);

    // Flush without stall: last stage commits, the rest is squashed
    step; issue(0, 2'd1, 3'd0, 3'd5, 32'h55);
    c0 = cyc; push(0, 5, 32'h55, c0 + 2);
    step; issue(0, 2'd1, 3'd0, 3'd6, 32'h56);
    step; issue(0, 2'd1, 3'd0, 3'd1, 32'h51); flush[0] = 1'b1;
    @(negedge clk); chk("fl_pend_a", {24'd0, pending[0]}, 32'h60);
    step; idle(0); flush[0] = 1'b0;
    @(negedge clk); chk("fl_pend_b", {24'd0, pending[0]}, 0);
    step;
    @(negedge clk); chk("fl_pend_c", {24'd0, pending[0]}, 0);

    for (int s = 0; s < 4; s++) step;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
